// File: rtl/cursor_ctrl.sv
// cursor_ctrl: board cursor navigation, piece select, move request handshake and pixel overlay
module cursor_ctrl #(
    parameter int SQ_SIZE    = 60,
    parameter int BOARD_X0   = 80,
    parameter int BOARD_Y0   = 0,
    parameter int BORDER     = 3,
    parameter int REPEAT_DLY = 12500000,
    parameter int REPEAT_PER = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_active,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    input  logic [9:0] pixel_row,
    input  logic [9:0] pixel_column,
    output logic [2:0] cursor,
    output logic       move_valid,
    output logic [5:0] move_from,
    output logic [5:0] move_to,
    input  logic       move_ready,
    output logic [5:0] cur_pos
);
    localparam int CW = $clog2(REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER) + 1;

    typedef enum logic [1:0] {IDLE, SELECTED, REQ} state_t;
    state_t state, state_n;

    logic [4:0] btn, btn_q, press;
    logic [3:0] ev;
    logic [CW-1:0] cnt;
    logic rep, held, fire, nav;
    logic [2:0] row, col;
    logic [5:0] pos_n, from_n, to_n;
    logic [9:0] cx, cy, sx, sy;
    logic c_hit, s_hit;

    function automatic logic outline(input logic [9:0] x, y, xl, yl);
        logic [9:0] xh, yh;
        xh = xl + 10'(SQ_SIZE - 1);
        yh = yl + 10'(SQ_SIZE - 1);
        outline = x >= xl && x <= xh && y >= yl && y <= yh &&
                  (x < xl + 10'(BORDER) || x > xh - 10'(BORDER) ||
                   y < yl + 10'(BORDER) || y > yh - 10'(BORDER));
    endfunction

    assign btn   = {btn_sel, btn_right, btn_left, btn_down, btn_up};
    assign press = btn & ~btn_q;
    assign held  = $onehot(btn[3:0]);
    assign fire  = held && !(|press[3:0]) &&
                   cnt == (rep ? CW'(REPEAT_PER - 1) : CW'(REPEAT_DLY - 1));
    assign ev    = press[3:0] | (fire ? btn[3:0] : 4'b0);
    assign row   = cur_pos[5:3];
    assign col   = cur_pos[2:0];
    // select wins over any direction step in the same cycle
    assign nav   = game_active && state != REQ && !press[4];
    assign pos_n = !nav  ? cur_pos :
                   ev[0] ? {row - 3'(row != 3'd0), col} :
                   ev[1] ? {row + 3'(row != 3'd7), col} :
                   ev[2] ? {row, col - 3'(col != 3'd0)} :
                   ev[3] ? {row, col + 3'(col != 3'd7)} : cur_pos;
    assign move_valid = state == REQ;
    assign c_hit = outline(pixel_column, pixel_row, cx, cy);
    assign s_hit = outline(pixel_column, pixel_row, sx, sy);

    always_comb begin
        state_n = state;
        from_n  = move_from;
        to_n    = move_to;
        if (!game_active) state_n = IDLE;
        else case (state)
            IDLE:     if (press[4]) begin
                          state_n = SELECTED;
                          from_n  = cur_pos;
                      end
            SELECTED: if (press[4]) begin
                          state_n = cur_pos == move_from ? IDLE : REQ;
                          to_n    = cur_pos == move_from ? move_to : cur_pos;
                      end
            REQ:      if (move_ready) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            btn_q     <= '0;
            cnt       <= '0;
            rep       <= 1'b0;
            cur_pos   <= '0;
            move_from <= '0;
            move_to   <= '0;
            cx        <= 10'(BOARD_X0);
            cy        <= 10'(BOARD_Y0);
            sx        <= 10'(BOARD_X0);
            sy        <= 10'(BOARD_Y0);
            cursor    <= '0;
        end else begin
            state     <= state_n;
            btn_q     <= btn;
            cur_pos   <= pos_n;
            move_from <= from_n;
            move_to   <= to_n;
            if (!held || !game_active) begin
                cnt <= '0;
                rep <= 1'b0;
            end else if (|press[3:0]) begin
                cnt <= CW'(1);
                rep <= 1'b0;
            end else if (fire) begin
                cnt <= '0;
                rep <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            // square bounds lag the position by one cycle, keeping multiplies off the pixel path
            cx <= 10'(BOARD_X0) + 10'(col) * 10'(SQ_SIZE);
            cy <= 10'(BOARD_Y0) + 10'(row) * 10'(SQ_SIZE);
            sx <= 10'(BOARD_X0) + 10'(move_from[2:0]) * 10'(SQ_SIZE);
            sy <= 10'(BOARD_Y0) + 10'(move_from[5:3]) * 10'(SQ_SIZE);
            cursor <= !game_active ? 3'd0 : c_hit ? 3'd1 :
                      (state != IDLE && s_hit) ? 3'd2 : 3'd0;
        end
    end
endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: directed scenario tests for cursor_ctrl with short repeat timing
module tb_cursor_ctrl;
    localparam int D = 20;
    localparam int P = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic game_active = 1'b1;
    logic [4:0] b = '0;
    logic [9:0] pixel_row = '0;
    logic [9:0] pixel_column = '0;
    logic move_ready = 1'b0;
    logic [2:0] cursor;
    logic move_valid;
    logic [5:0] move_from, move_to, cur_pos;
    int vecs = 0;
    int errs = 0;

    cursor_ctrl #(.REPEAT_DLY(D), .REPEAT_PER(P)) dut (
        .clk(clk), .reset(reset), .game_active(game_active),
        .btn_up(b[0]), .btn_down(b[1]), .btn_left(b[2]), .btn_right(b[3]), .btn_sel(b[4]),
        .pixel_row(pixel_row), .pixel_column(pixel_column),
        .cursor(cursor), .move_valid(move_valid), .move_from(move_from),
        .move_to(move_to), .move_ready(move_ready), .cur_pos(cur_pos)
    );

    always #20 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int idx);
        b[idx] = 1'b1;
        tick();
        b[idx] = 1'b0;
        tick();
    endtask

    task automatic pix(input logic [9:0] r, input logic [9:0] c, output logic [2:0] v);
        pixel_row = r;
        pixel_column = c;
        tick();
        v = cursor;
    endtask

    task automatic test_reset;
        logic [2:0] v;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vecs++; if (cur_pos !== 6'o00) begin errs++; $display("FAIL reset_pos got %o want 00", cur_pos); end
        vecs++; if (move_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", move_valid); end
        vecs++; if (cursor !== 3'd0) begin errs++; $display("FAIL reset_cursor got %0d want 0", cursor); end
        vecs++; if ({move_from, move_to} !== 12'o0000) begin errs++; $display("FAIL reset_move got %o want 0000", {move_from, move_to}); end
        press(2);
        press(0);
        vecs++; if (cur_pos !== 6'o00) begin errs++; $display("FAIL clamp_pos got %o want 00", cur_pos); end
        pix(10'd0, 10'd80, v);
        vecs++; if (v !== 3'd1) begin errs++; $display("FAIL pix_corner got %0d want 1", v); end
        pix(10'd30, 10'd110, v);
        vecs++; if (v !== 3'd0) begin errs++; $display("FAIL pix_interior got %0d want 0", v); end
        pix(10'd2, 10'd82, v);
        vecs++; if (v !== 3'd1) begin errs++; $display("FAIL pix_border_in got %0d want 1", v); end
        pix(10'd3, 10'd83, v);
        vecs++; if (v !== 3'd0) begin errs++; $display("FAIL pix_border_out got %0d want 0", v); end
        pix(10'd59, 10'd139, v);
        vecs++; if (v !== 3'd1) begin errs++; $display("FAIL pix_far_corner got %0d want 1", v); end
        pix(10'd0, 10'd140, v);
        vecs++; if (v !== 3'd0) begin errs++; $display("FAIL pix_next_square got %0d want 0", v); end
        pix(10'd0, 10'd79, v);
        vecs++; if (v !== 3'd0) begin errs++; $display("FAIL pix_off_board got %0d want 0", v); end
    endtask

    task automatic test_auto_repeat;
        logic [2:0] exp_col = 3'd0;
        b[3] = 1'b1;
        for (int k = 0; k < D + 3 * P; k++) begin
            tick();
            if (k == 0 || k == D - 1 || (k > D - 1 && (k - (D - 1)) % P == 0)) exp_col++;
            vecs++; if (cur_pos !== {3'd0, exp_col}) begin errs++; $display("FAIL repeat_k%0d got %o want %o", k, cur_pos, {3'd0, exp_col}); end
        end
        b[3] = 1'b0;
        tick();
        vecs++; if (cur_pos !== 6'o05) begin errs++; $display("FAIL repeat_release got %o want 05", cur_pos); end
    endtask

    task automatic test_handshake;
        logic [2:0] v;
        for (int i = 0; i < 5; i++) press(2);
        vecs++; if (cur_pos !== 6'o00) begin errs++; $display("FAIL hs_home got %o want 00", cur_pos); end
        press(4);
        vecs++; if (move_valid !== 1'b0) begin errs++; $display("FAIL hs_selected_valid got %b want 0", move_valid); end
        press(1);
        press(1);
        press(3);
        press(4);
        vecs++; if (move_valid !== 1'b1) begin errs++; $display("FAIL hs_valid got %b want 1", move_valid); end
        vecs++; if (move_from !== 6'o00) begin errs++; $display("FAIL hs_from got %o want 00", move_from); end
        vecs++; if (move_to !== 6'o21) begin errs++; $display("FAIL hs_to got %o want 21", move_to); end
        pix(10'd0, 10'd80, v);
        vecs++; if (v !== 3'd2) begin errs++; $display("FAIL hs_sel_outline got %0d want 2", v); end
        b[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b[4] = i[0];
            b[3] = ~i[0];
            tick();
            vecs++; if ({move_valid, move_from, move_to, cur_pos} !== {1'b1, 6'o00, 6'o21, 6'o21})
                begin errs++; $display("FAIL hs_hold_%0d got %b %o %o %o want 1 00 21 21", i, move_valid, move_from, move_to, cur_pos); end
        end
        b = '0;
        tick();
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
        vecs++; if (move_valid !== 1'b0) begin errs++; $display("FAIL hs_done got %b want 0", move_valid); end
        pix(10'd0, 10'd80, v);
        vecs++; if (v !== 3'd0) begin errs++; $display("FAIL hs_idle_outline got %0d want 0", v); end
    endtask

    task automatic test_cancel;
        logic [2:0] v;
        press(1);
        press(3);
        press(3);
        vecs++; if (cur_pos !== 6'o33) begin errs++; $display("FAIL cancel_pos got %o want 33", cur_pos); end
        press(4);
        press(3);
        pix(10'd180, 10'd260, v);
        vecs++; if (v !== 3'd2) begin errs++; $display("FAIL cancel_sel_outline got %0d want 2", v); end
        press(2);
        press(4);
        vecs++; if (move_valid !== 1'b0) begin errs++; $display("FAIL cancel_valid got %b want 0", move_valid); end
        pix(10'd180, 10'd260, v);
        vecs++; if (v !== 3'd1) begin errs++; $display("FAIL cancel_cursor got %0d want 1", v); end
        press(3);
        pix(10'd180, 10'd260, v);
        vecs++; if (v !== 3'd0) begin errs++; $display("FAIL cancel_no_code2 got %0d want 0", v); end
        pix(10'd180, 10'd322, v);
        vecs++; if (v !== 3'd1) begin errs++; $display("FAIL cancel_new_cursor got %0d want 1", v); end
    endtask

    task automatic test_simultaneous;
        logic [2:0] v;
        press(1);
        vecs++; if (cur_pos !== 6'o44) begin errs++; $display("FAIL sim_start got %o want 44", cur_pos); end
        b[0] = 1'b1;
        b[3] = 1'b1;
        tick();
        b = '0;
        tick();
        vecs++; if (cur_pos !== 6'o34) begin errs++; $display("FAIL sim_priority got %o want 34", cur_pos); end
        b[4] = 1'b1;
        b[1] = 1'b1;
        tick();
        b = '0;
        tick();
        vecs++; if (cur_pos !== 6'o34) begin errs++; $display("FAIL sim_sel_wins got %o want 34", cur_pos); end
        vecs++; if (move_valid !== 1'b0) begin errs++; $display("FAIL sim_valid got %b want 0", move_valid); end
        press(3);
        pix(10'd180, 10'd320, v);
        vecs++; if (v !== 3'd2) begin errs++; $display("FAIL sim_selected got %0d want 2", v); end
    endtask

    task automatic test_context_loss;
        logic [2:0] v;
        press(4);
        vecs++; if ({move_valid, move_from, move_to} !== {1'b1, 6'o34, 6'o35})
            begin errs++; $display("FAIL ctx_req got %b %o %o want 1 34 35", move_valid, move_from, move_to); end
        pixel_row = 10'd180;
        pixel_column = 10'd380;
        tick();
        vecs++; if (cursor !== 3'd1) begin errs++; $display("FAIL ctx_cursor_on got %0d want 1", cursor); end
        game_active = 1'b0;
        tick();
        vecs++; if (move_valid !== 1'b0) begin errs++; $display("FAIL ctx_valid got %b want 0", move_valid); end
        vecs++; if (cursor !== 3'd0) begin errs++; $display("FAIL ctx_cursor got %0d want 0", cursor); end
        game_active = 1'b1;
        tick();
        vecs++; if (move_valid !== 1'b0) begin errs++; $display("FAIL ctx_resume_valid got %b want 0", move_valid); end
        vecs++; if (cur_pos !== 6'o35) begin errs++; $display("FAIL ctx_pos got %o want 35", cur_pos); end
        pix(10'd180, 10'd380, v);
        vecs++; if (v !== 3'd1) begin errs++; $display("FAIL ctx_cursor_back got %0d want 1", v); end
        pix(10'd180, 10'd320, v);
        vecs++; if (v !== 3'd0) begin errs++; $display("FAIL ctx_idle got %0d want 0", v); end
    endtask

    task automatic test_reset_mid_req;
        press(4);
        press(2);
        press(4);
        vecs++; if (move_valid !== 1'b1) begin errs++; $display("FAIL rst_req got %b want 1", move_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vecs++; if (move_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", move_valid); end
        vecs++; if (cur_pos !== 6'o00) begin errs++; $display("FAIL rst_pos got %o want 00", cur_pos); end
    endtask

    initial begin
        test_reset();
        test_auto_repeat();
        test_handshake();
        test_cancel();
        test_simultaneous();
        test_context_loss();
        test_reset_mid_req();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
